// File: rtl/spi_csr_bridge.sv
// SPI (mode 0) slave that turns command/data byte frames into single-cycle CSR read/write strobes.
// Optional macro SPI_MISO_TRISTATE_EN: release spi_miso to high impedance while deselected or in reset.
module spi_csr_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_nss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, nss_sync_q, mosi_sync_q;
  logic sck_prev_q, nss_prev_q;
  logic sck_s, nss_s, mosi_s;
  logic sck_rise, sck_fall, nss_fall, nss_rise;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [4:0] addr_q, addr_d;
  logic       wr_mode_q, wr_mode_d;
  logic       inc_q, inc_d;
  logic       pend_q, pend_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] byte_nxt;

  // nss synchronizer resets low so a frame needs a fresh high->low after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= '0;
      nss_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      nss_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign nss_s    = nss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign nss_fall = ~nss_s & nss_prev_q;
  assign nss_rise = nss_s & ~nss_prev_q;
  assign byte_nxt = {rx_sr_q[6:0], mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      tx_sr_q   <= '0;
      addr_q    <= '0;
      wr_mode_q <= 1'b0;
      inc_q     <= 1'b0;
      pend_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      tx_sr_q   <= tx_sr_d;
      addr_q    <= addr_d;
      wr_mode_q <= wr_mode_d;
      inc_q     <= inc_d;
      pend_q    <= pend_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    tx_sr_d   = tx_sr_q;
    addr_d    = addr_q;
    wr_mode_d = wr_mode_q;
    inc_d     = inc_q;
    wdata_d   = wdata_q;
    pend_d    = 1'b0;
    // strobe one cycle after the byte completes so the address leads it by a cycle
    rd_d      = pend_q & ~wr_mode_q;
    wr_d      = pend_q & wr_mode_q;

    if ((rd_q || wr_q) && inc_q) addr_d = addr_q + 5'd1;

    if (rd_q) begin
      tx_sr_d = csr_readdata;
    end else if (sck_fall && state_q != IDLE && bit_cnt_q != 3'd0) begin
      tx_sr_d = {tx_sr_q[6:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        if (nss_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
        end
      end
      default: begin
        if (nss_rise) begin
          // partial byte and any prefetched read byte are dropped
          state_d   = IDLE;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          tx_sr_d   = '0;
        end else if (sck_rise) begin
          rx_sr_d   = byte_nxt;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_d   = DATA;
              wr_mode_d = byte_nxt[7];
              inc_d     = byte_nxt[6];
              addr_d    = byte_nxt[4:0];
              pend_d    = ~byte_nxt[7];
            end else begin
              pend_d = 1'b1;
              if (wr_mode_q) wdata_d = byte_nxt;
            end
          end
        end
      end
    endcase
  end

  assign csr_address   = addr_q;
  assign csr_read      = rd_q;
  assign csr_write     = wr_q;
  assign csr_writedata = wdata_q;

`ifdef SPI_MISO_TRISTATE_EN
  assign spi_miso = (nss_s || reset) ? 1'bz : tx_sr_q[7];
`else
  assign spi_miso = (nss_s || reset) ? 1'b0 : tx_sr_q[7];
`endif

endmodule

// File: doc/spi_csr_bridge.md
SPI_CSR_BRIDGE -- requirements
Module: spi_csr_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth (>=2) for spi_sck, spi_nss and spi_mosi.
REQ-002 SHALL have port clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), at most clk/8.
REQ-005 SHALL have port spi_nss  input  1  SPI chip select, active-low.
REQ-006 SHALL have port spi_mosi  input  1  host-to-bridge serial data, MSB first.
REQ-007 SHALL have port spi_miso  output  1  bridge-to-host serial data, MSB first.
REQ-008 SHALL have port csr_address  output  5  CSR address to the downstream controller.
REQ-009 SHALL have port csr_read  output  1  one-cycle read strobe.
REQ-010 SHALL have port csr_readdata  input  8  combinational read data, valid in the csr_read cycle.
REQ-011 SHALL have port csr_write  output  1  one-cycle write strobe.
REQ-012 SHALL have port csr_writedata  output  8  write data, valid with csr_write.

Function
REQ-013 SHALL synchronize spi_sck, spi_nss and spi_mosi through SYNC_STAGES flops and detect sck rise/fall and nss fall/rise on the synchronized signals.
REQ-014 SHALL implement states IDLE, CMD and DATA; IDLE->CMD on nss fall, CMD->DATA after 8 command bits, any state->IDLE on nss rise.
REQ-015 SHALL sample mosi on each sck rise into an 8-bit shift register and maintain a 3-bit bit counter, cleared on nss fall and wrapping 7->0.
REQ-016 SHALL decode the command byte as: bit7 write(1)/read(0), bit6 auto-increment, bit5 ignored, bits4:0 start address.
REQ-017 SHALL, on the 8th rise of each write data byte, drive csr_writedata=byte and csr_address=current address, and pulse csr_write for exactly one clk in the following cycle.
REQ-018 SHALL, for reads, pulse csr_read for one clk after the 8th rise of the command byte and after the 8th rise of every data byte, and load csr_readdata into the tx shift register in that same cycle.
REQ-019 SHALL, as a consequence of REQ-018, issue N+1 csr_read pulses for an N-byte read burst; the final prefetched byte is discarded at nss rise.
REQ-020 SHALL drive spi_miso from tx shift register bit7 and shift it left on sck fall only when the bit counter is nonzero; shift-in value is 0.
REQ-021 SHALL, in the cycle after each csr strobe, increment the 5-bit address with wrap 0x1f->0x00 when the auto-increment bit is set, and otherwise hold it.
REQ-022 SHALL hold csr_address stable from one cycle before each strobe through the strobe cycle, and never assert csr_read and csr_write in the same cycle.
REQ-023 SHALL, on nss rise mid-byte, discard the partial byte and issue no strobe for it.
REQ-024 SHALL, when nss rise and the 8th sck rise are seen in the same cycle, give nss priority, issuing no strobe.
REQ-025 SHALL ignore sck edges while in IDLE.

Reset
REQ-026 SHALL, on reset, force state=IDLE, bit counter=0, shift registers=0, csr_address=0, csr_read=0, csr_write=0, csr_writedata=0 and spi_miso per REQ-028/029.
REQ-027 SHALL reset the nss synchronizer to 0, so a frame begins only after nss is seen high and then low after reset deasserts; reset mid-frame aborts the frame with no strobe.

Configuration
REQ-028 SHALL, when SPI_MISO_TRISTATE_EN is defined, drive spi_miso to high impedance whenever synchronized nss is high or reset is asserted.
REQ-029 SHALL, when SPI_MISO_TRISTATE_EN is undefined, drive spi_miso to 0 whenever synchronized nss is high or reset is asserted.

Verification
REQ-030 SHALL cover a single write: frame 0x86,0x5A -> one csr_write with csr_address=0x06 and csr_writedata=0x5A, and no csr_read.
REQ-031 SHALL cover a write burst with increment: 0xDF,0x11,0x22 -> csr_write at 0x1F with data 0x11, then at 0x00 with data 0x22.
REQ-032 SHALL cover a read without increment: 0x0C plus 2 dummy bytes, csr_readdata=0xA5 then 0x3C -> three csr_read pulses at address 0x0C, and miso bytes 0xA5, 0x3C.
REQ-033 SHALL cover an abort: 0x85 then nss rise after 5 data bits -> no csr_write, state IDLE, and the next frame 0x85,0x01 writes 0x01 to address 0x05.
REQ-034 SHALL cover reset mid-frame: reset asserted during the 3rd data byte with nss held low -> no strobes until nss goes high then low, and spi_miso is Z or 0 per macro.
